// File: rtl/wb_rr_arbiter_if.sv
// Bus bundle for the round-robin Wishbone arbiter: NM master ports plus one
// shared slave port. The "master" modport is the arbiter's view (it masters
// the shared slave bus); "slave" is the surrounding environment's view.
interface wb_rr_arbiter_if #(
    parameter int NM = 2,
    parameter int AW = 32,
    parameter int DW = 32
);
    // master-facing side
    logic [NM*AW-1:0]     wbm_adr_i;
    logic [NM*DW-1:0]     wbm_dat_i;
    logic [NM*(DW/8)-1:0] wbm_sel_i;
    logic [NM-1:0]        wbm_we_i;
    logic [NM-1:0]        wbm_cyc_i;
    logic [NM-1:0]        wbm_stb_i;
    logic [NM*3-1:0]      wbm_cti_i;
    logic [NM*2-1:0]      wbm_bte_i;
    logic [DW-1:0]        wbm_dat_o;
    logic [NM-1:0]        wbm_ack_o;
    logic [NM-1:0]        wbm_err_o;
    // slave-facing side
    logic [AW-1:0]        wbs_adr_o;
    logic [DW-1:0]        wbs_dat_o;
    logic [DW/8-1:0]      wbs_sel_o;
    logic                 wbs_we_o;
    logic                 wbs_cyc_o;
    logic                 wbs_stb_o;
    logic [2:0]           wbs_cti_o;
    logic [1:0]           wbs_bte_o;
    logic [DW-1:0]        wbs_dat_i;
    logic                 wbs_ack_i;
    logic                 wbs_err_i;

    modport master (
        input  wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i,
               wbm_cti_i, wbm_bte_i, wbs_dat_i, wbs_ack_i, wbs_err_i,
        output wbm_dat_o, wbm_ack_o, wbm_err_o, wbs_adr_o, wbs_dat_o, wbs_sel_o,
               wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o
    );

    modport slave (
        output wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i,
               wbm_cti_i, wbm_bte_i, wbs_dat_i, wbs_ack_i, wbs_err_i,
        input  wbm_dat_o, wbm_ack_o, wbm_err_o, wbs_adr_o, wbs_dat_o, wbs_sel_o,
               wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o
    );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B3 arbiter: NM masters share one slave port. The owner
// holds the bus while its cyc stays high; an ack watchdog turns a hung access
// into a one-cycle error to the owner.
module wb_rr_arbiter #(
    parameter int NM      = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255,
    parameter int CW      = 8
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_n_i,
    wb_rr_arbiter_if.master       bus,
    output logic [NM-1:0]         grant_o
);
    localparam int IW = (NM > 1) ? $clog2(NM) : 1;
    localparam int SW = DW / 8;

    typedef enum logic [1:0] {IDLE, GRANT, TERR} state_t;

    state_t          state_q, state_d;
    logic [NM-1:0]   grant_q, grant_d;
    logic [IW-1:0]   last_q, last_d;   // last winner; doubles as owner index
    logic [CW-1:0]   wd_q;

    logic [IW-1:0]   win, idx, sel;
    logic            found;
    logic            own_cyc, own_stb, wd_hit;
    logic            cyc_o, stb_o;
    logic [NM-1:0]   ack_o, err_o;

    logic [AW-1:0]   s_adr;
    logic [DW-1:0]   s_dat;
    logic [SW-1:0]   s_sel;
    logic            s_we;
    logic [2:0]      s_cti;
    logic [1:0]      s_bte;

    assign own_cyc = bus.wbm_cyc_i[last_q];
    assign own_stb = own_cyc & bus.wbm_stb_i[last_q];
    assign wd_hit  = (TIMEOUT != 0) && (wd_q == CW'(TIMEOUT)) && own_stb &&
                     !bus.wbs_ack_i && !bus.wbs_err_i;

    // Round-robin search: first requester starting after the last winner
    always_comb begin
        win   = last_q;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NM; k++) begin
            idx = IW'((int'(last_q) + k) % NM);
            if (!found && bus.wbm_cyc_i[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Slave field mux: master 0 while idle, the owner otherwise
    always_comb begin
        sel   = (state_q == IDLE) ? '0 : last_q;
        s_adr = bus.wbm_adr_i[0 +: AW];
        s_dat = bus.wbm_dat_i[0 +: DW];
        s_sel = bus.wbm_sel_i[0 +: SW];
        s_we  = bus.wbm_we_i[0];
        s_cti = bus.wbm_cti_i[0 +: 3];
        s_bte = bus.wbm_bte_i[0 +: 2];
        for (int i = 1; i < NM; i++) begin
            if (sel == IW'(i)) begin
                s_adr = bus.wbm_adr_i[i*AW +: AW];
                s_dat = bus.wbm_dat_i[i*DW +: DW];
                s_sel = bus.wbm_sel_i[i*SW +: SW];
                s_we  = bus.wbm_we_i[i];
                s_cti = bus.wbm_cti_i[i*3 +: 3];
                s_bte = bus.wbm_bte_i[i*2 +: 2];
            end
        end
    end

    // Next-state and bus-control outputs
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cyc_o   = 1'b0;
        stb_o   = 1'b0;
        ack_o   = '0;
        err_o   = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                    last_d       = win;
                    state_d      = GRANT;
                end
            end
            GRANT: begin
                cyc_o = own_cyc;
                stb_o = own_stb;
                // gate with cyc so a late ack after the owner quits goes nowhere
                ack_o[last_q] = bus.wbs_ack_i & own_cyc;
                err_o[last_q] = bus.wbs_err_i & own_cyc;
                if (!own_cyc) begin
                    state_d = IDLE;
                    grant_d = '0;
                end else if (wd_hit) begin
                    state_d = TERR;
                end
            end
            TERR: begin
                // slave is released this cycle; any ack it returns is dropped
                err_o[last_q] = 1'b1;
                if (own_cyc) begin
                    state_d = GRANT;
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State, grant and round-robin pointer registers
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IW'(NM - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // Watchdog: counts stalled strobe cycles in GRANT, saturating at TIMEOUT
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wd_q <= '0;
        end else if (state_q == GRANT && state_d == GRANT && own_stb &&
                     !bus.wbs_ack_i && !bus.wbs_err_i) begin
            if (wd_q != CW'(TIMEOUT)) wd_q <= wd_q + 1'b1;
        end else begin
            wd_q <= '0;
        end
    end

    assign grant_o       = grant_q;
    assign bus.wbm_dat_o = bus.wbs_dat_i;
    assign bus.wbm_ack_o = ack_o;
    assign bus.wbm_err_o = err_o;
    assign bus.wbs_cyc_o = cyc_o;
    assign bus.wbs_stb_o = stb_o;
    assign bus.wbs_adr_o = s_adr;
    assign bus.wbs_dat_o = s_dat;
    assign bus.wbs_sel_o = s_sel;
    assign bus.wbs_we_o  = s_we;
    assign bus.wbs_cti_o = s_cti;
    assign bus.wbs_bte_o = s_bte;
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter (NM=2, TIMEOUT=4). Inputs change 1ns after
// the rising edge; outputs are sampled on the falling edge.
module tb_wb_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] grant;
    int         n_tests = 0;
    int         n_fail  = 0;

    wb_rr_arbiter_if #(.NM(2), .AW(32), .DW(32)) bus ();

    wb_rr_arbiter #(.NM(2), .AW(32), .DW(32), .TIMEOUT(4), .CW(8)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .bus        (bus),
        .grant_o    (grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    task automatic set_m(input int m, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat, input logic [2:0] cti);
        bus.wbm_cyc_i[m]         = cyc;
        bus.wbm_stb_i[m]         = stb;
        bus.wbm_we_i[m]          = we;
        bus.wbm_adr_i[m*32 +: 32] = adr;
        bus.wbm_dat_i[m*32 +: 32] = dat;
        bus.wbm_cti_i[m*3 +: 3]  = cti;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1);
    end

    initial begin
        rst_n         = 1'b0;
        bus.wbm_adr_i = '0;
        bus.wbm_dat_i = '0;
        bus.wbm_sel_i = '1;
        bus.wbm_we_i  = '0;
        bus.wbm_cyc_i = '0;
        bus.wbm_stb_i = '0;
        bus.wbm_cti_i = '0;
        bus.wbm_bte_i = '0;
        bus.wbs_dat_i = '0;
        bus.wbs_ack_i = 1'b0;
        bus.wbs_err_i = 1'b0;
        set_m(0, 0, 0, 0, 32'h55, 32'h0, 3'd0);
        set_m(1, 0, 0, 0, 32'hAA, 32'h0, 3'd0);

        // reset state
        #12;
        chk("rst_grant", grant, 2'b00);
        chk("rst_cyc", bus.wbs_cyc_o, 1'b0);
        chk("rst_stb", bus.wbs_stb_o, 1'b0);
        chk("rst_ack", bus.wbm_ack_o, 2'b00);
        chk("rst_err", bus.wbm_err_o, 2'b00);
        chk("rst_adr_m0", bus.wbs_adr_o, 32'h55);
        mid;
        rst_n = 1'b1;

        // single master write, two wait states
        nxt; set_m(0, 1, 1, 1, 32'h100, 32'hDEADBEEF, 3'd0);
        mid; chk("t1_arb_cyc", bus.wbs_cyc_o, 1'b0);
             chk("t1_arb_grant", grant, 2'b00);
        nxt; mid;
        chk("t1_cyc", bus.wbs_cyc_o, 1'b1);
        chk("t1_stb", bus.wbs_stb_o, 1'b1);
        chk("t1_adr", bus.wbs_adr_o, 32'h100);
        chk("t1_dat", bus.wbs_dat_o, 32'hDEADBEEF);
        chk("t1_we", bus.wbs_we_o, 1'b1);
        chk("t1_grant", grant, 2'b01);
        chk("t1_ws1_ack", bus.wbm_ack_o, 2'b00);
        nxt; mid; chk("t1_ws2_ack", bus.wbm_ack_o, 2'b00);
        nxt; bus.wbs_ack_i = 1'b1;
        mid; chk("t1_ack", bus.wbm_ack_o, 2'b01);
        nxt; bus.wbs_ack_i = 1'b0; set_m(0, 0, 0, 0, 32'h100, 32'h0, 3'd0);
        mid; chk("t1_drop_cyc", bus.wbs_cyc_o, 1'b0);
             chk("t1_drop_ack", bus.wbm_ack_o, 2'b00);
             chk("t1_drop_grant", grant, 2'b01);
        nxt; mid; chk("t1_idle_grant", grant, 2'b00);

        // contention straight out of reset: m0 first, idle gap, then m1
        rst_n = 1'b0;
        nxt; nxt; rst_n = 1'b1;
        set_m(0, 1, 1, 0, 32'h200, 32'h0, 3'd0);
        set_m(1, 1, 1, 0, 32'h300, 32'h0, 3'd0);
        mid; chk("t2_arb_grant", grant, 2'b00);
        nxt; bus.wbs_dat_i = 32'h1234; bus.wbs_ack_i = 1'b1;
        mid; chk("t2_m0_grant", grant, 2'b01);
             chk("t2_m0_adr", bus.wbs_adr_o, 32'h200);
             chk("t2_m0_ack", bus.wbm_ack_o, 2'b01);
             chk("t2_rdata", bus.wbm_dat_o, 32'h1234);
        nxt; bus.wbs_ack_i = 1'b0; set_m(0, 0, 0, 0, 32'h200, 32'h0, 3'd0);
        mid; chk("t2_m0_drop_cyc", bus.wbs_cyc_o, 1'b0);
        nxt; mid; chk("t2_gap_grant", grant, 2'b00);
                  chk("t2_gap_cyc", bus.wbs_cyc_o, 1'b0);
        nxt; bus.wbs_ack_i = 1'b1;
        mid; chk("t2_m1_grant", grant, 2'b10);
             chk("t2_m1_adr", bus.wbs_adr_o, 32'h300);
             chk("t2_m1_ack", bus.wbm_ack_o, 2'b10);
        nxt; bus.wbs_ack_i = 1'b0; set_m(1, 0, 0, 0, 32'h300, 32'h0, 3'd0);
        mid;
        nxt; mid; chk("t2_end_grant", grant, 2'b00);

        // m0 alone, then contention with m0 last: m1 must win
        nxt; set_m(0, 1, 1, 0, 32'h400, 32'h0, 3'd0);
        mid;
        nxt; bus.wbs_ack_i = 1'b1;
        mid; chk("t2b_m0_ack", bus.wbm_ack_o, 2'b01);
        nxt; bus.wbs_ack_i = 1'b0; set_m(0, 0, 0, 0, 32'h400, 32'h0, 3'd0);
        mid;
        nxt; mid;
        nxt; set_m(0, 1, 1, 0, 32'h480, 32'h0, 3'd0);
             set_m(1, 1, 1, 0, 32'h500, 32'h0, 3'd2);
        mid; chk("t2b_arb_grant", grant, 2'b00);
        nxt; mid; chk("t2b_rr_grant", grant, 2'b10);
                  chk("t2b_rr_adr", bus.wbs_adr_o, 32'h500);

        // 8-beat burst by m1 while m0 waits
        for (int b = 0; b < 8; b++) begin
            nxt;
            set_m(1, 1, 1, 0, 32'h500 + 32'(b * 4), 32'h0, (b == 7) ? 3'd7 : 3'd2);
            bus.wbs_ack_i = 1'b1;
            mid;
            chk($sformatf("t3_b%0d_grant", b), grant, 2'b10);
            chk($sformatf("t3_b%0d_ack", b), bus.wbm_ack_o, 2'b10);
            chk($sformatf("t3_b%0d_cti", b), bus.wbs_cti_o, (b == 7) ? 3'd7 : 3'd2);
        end
        nxt; bus.wbs_ack_i = 1'b0; set_m(1, 0, 0, 0, 32'h0, 32'h0, 3'd0);
        mid; chk("t3_drop_cyc", bus.wbs_cyc_o, 1'b0);
        nxt; mid; chk("t3_gap_grant", grant, 2'b00);

        // watchdog: m0 strobes, slave never acks
        nxt; mid; chk("t4_g0_grant", grant, 2'b01);
                  chk("t4_g0_stb", bus.wbs_stb_o, 1'b1);
                  chk("t4_g0_err", bus.wbm_err_o, 2'b00);
        for (int g = 1; g <= 4; g++) begin
            nxt; mid;
            chk($sformatf("t4_g%0d_err", g), bus.wbm_err_o, 2'b00);
            chk($sformatf("t4_g%0d_stb", g), bus.wbs_stb_o, 1'b1);
        end
        nxt; bus.wbs_ack_i = 1'b1;
        mid; chk("t4_terr_err", bus.wbm_err_o, 2'b01);
             chk("t4_terr_stb", bus.wbs_stb_o, 1'b0);
             chk("t4_terr_cyc", bus.wbs_cyc_o, 1'b0);
             chk("t4_terr_ack", bus.wbm_ack_o, 2'b00);
        nxt; bus.wbs_ack_i = 1'b0;
        mid; chk("t4_back_stb", bus.wbs_stb_o, 1'b1);
             chk("t4_back_err", bus.wbm_err_o, 2'b00);
             chk("t4_back_grant", grant, 2'b01);
        nxt; set_m(0, 0, 0, 0, 32'h0, 32'h0, 3'd0);
        mid;
        nxt; mid;

        // slave err on an m1 read, then an ack landing as the counter saturates
        nxt; set_m(1, 1, 1, 0, 32'h600, 32'h0, 3'd0);
        mid;
        nxt; bus.wbs_err_i = 1'b1;
        mid; chk("t5_err", bus.wbm_err_o, 2'b10);
             chk("t5_grant", grant, 2'b10);
        nxt; bus.wbs_err_i = 1'b0;
        mid; chk("t5_no_terr_stb", bus.wbs_stb_o, 1'b1);
             chk("t5_no_terr_err", bus.wbm_err_o, 2'b00);
        nxt; mid; nxt; mid; nxt; mid;
        nxt; bus.wbs_ack_i = 1'b1;
        mid; chk("t5_ack_at_limit", bus.wbm_ack_o, 2'b10);
             chk("t5_ack_at_limit_err", bus.wbm_err_o, 2'b00);
        nxt; bus.wbs_ack_i = 1'b0;
        mid; chk("t5_after_stb", bus.wbs_stb_o, 1'b1);
             chk("t5_after_err", bus.wbm_err_o, 2'b00);
        nxt; set_m(1, 0, 0, 0, 32'h0, 32'h0, 3'd0);
        mid;
        nxt; mid;

        // reset during beat 3 of an m0 burst
        nxt; set_m(0, 1, 1, 0, 32'h700, 32'h0, 3'd2);
        mid;
        nxt; mid; chk("t6_grant", grant, 2'b01);
        for (int b = 0; b < 3; b++) begin
            nxt; bus.wbs_ack_i = 1'b1;
            mid;
        end
        nxt; mid; chk("t6_beat3_stb", bus.wbs_stb_o, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_cyc", bus.wbs_cyc_o, 1'b0);
        chk("t6_rst_grant", grant, 2'b00);
        chk("t6_rst_ack", bus.wbm_ack_o, 2'b00);
        chk("t6_rst_err", bus.wbm_err_o, 2'b00);
        #2;
        bus.wbs_ack_i = 1'b0;
        set_m(1, 1, 1, 0, 32'h800, 32'h0, 3'd0);
        rst_n = 1'b1;
        nxt; mid; chk("t6_post_grant", grant, 2'b01);
                  chk("t6_post_adr", bus.wbs_adr_o, 32'h700);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
